if_stage: RTL
=============

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk_i  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-004 stall_i  input  1  decode not accepting; hold IF/ID contents.
REQ-005 redirect_i  input  1  taken branch/jump; flush and refetch.
REQ-006 redirect_pc_i  input  32  new fetch address; bits [1:0] ignored.
REQ-007 imem_req_o  output  1  instruction memory read request, one-cycle pulse.
REQ-008 imem_addr_o  output  32  fetch address, valid while imem_req_o=1.
REQ-009 imem_rvalid_i  input  1  read data valid, any cycle after the request.
REQ-010 imem_rdata_i  input  32  instruction word.
REQ-011 if_valid_o  output  1  IF/ID register holds a live instruction.
REQ-012 if_pc_o / if_pc_plus4_o  output  32 each  PC of held instruction and PC+4.
REQ-013 if_instr_o  output  32  held instruction.
REQ-014 if_opcode_o 7, if_funct3_o 3, if_funct7_o 7  outputs  slices [6:0], [14:12], [31:25] of if_instr_o, feeding the control unit.

Function
REQ-015 FSM states IDLE, FETCH, WAIT, DRAIN; at most one memory request outstanding.
REQ-016 IDLE: entered on reset; unconditionally -> FETCH next cycle; imem_req_o=0.
REQ-017 FETCH: imem_req_o=1, imem_addr_o=pc_q, -> WAIT, only when if_valid_o=0 or stall_i=0; otherwise req=0, stay FETCH.
REQ-018 WAIT, imem_rvalid_i=1, redirect_i=0: load if_instr_o=imem_rdata_i, if_pc_o=pc_q, if_valid_o=1; pc_q+=4; -> FETCH.
REQ-019 WAIT, redirect_i=1, imem_rvalid_i=0: pc_q=redirect_pc_i with [1:0]=00; -> DRAIN.
REQ-020 WAIT, redirect_i=1 and imem_rvalid_i=1 same cycle: response discarded, pc_q=redirect target, -> FETCH.
REQ-021 DRAIN: imem_req_o=0; on imem_rvalid_i discard data, -> FETCH; redirect_i in DRAIN updates pc_q, stays DRAIN.
REQ-022 FETCH, redirect_i=1: no request that cycle; pc_q=redirect target; stay FETCH.
REQ-023 Consumption: if_valid_o=1 and stall_i=0 at an edge with no new load -> if_valid_o=0.
REQ-024 stall_i=1: if_valid_o, if_pc_o, if_instr_o unchanged.
REQ-025 redirect_i=1 clears if_valid_o and loads if_instr_o=32'h0000_0013 (NOP); redirect has priority over stall_i.
REQ-026 pc_q[1:0] always 2'b00; PC arithmetic modulo 2^32 (32'hFFFF_FFFC+4=0).
REQ-027 if_pc_plus4_o = if_pc_o+4, combinational, same wrap rule.
REQ-028 Minimum fetch throughput: one instruction per two cycles with single-cycle memory latency.

Reset
REQ-029 rst_n_i low: state IDLE, pc_q=RESET_PC, imem_req_o=0, if_valid_o=0, if_pc_o=0, if_instr_o=32'h0000_0013, immediately and independent of clk_i.
REQ-030 Reset mid-WAIT: outstanding response arriving after release is ignored unless FSM is in WAIT.

Configuration
REQ-031 Macro IF_PERF_COUNT_EN defined: outputs fetch_count_o (32) and flush_count_o (32) exist, counting loads per REQ-018 and redirects per REQ-025, saturating at 32'hFFFF_FFFF, reset to 0.
REQ-032 IF_PERF_COUNT_EN undefined: those ports and counters do not exist; all other behaviour identical.

Verification
REQ-033 Reset release, 1-cycle memory returning 32'h0000_0093 -> request addr 0x0 on cycle 2, if_valid_o=1, if_opcode_o=7'h13, if_pc_o=0; next request addr 0x4.
REQ-034 Hold stall_i=1 with if_valid_o=1 for 5 cycles -> no imem_req_o, outputs stable; drop stall -> request for next PC issued same cycle.
REQ-035 redirect_i=1, redirect_pc_i=32'h0000_0103 during WAIT, rvalid 3 cycles later -> data discarded, if_valid_o=0, next request addr 32'h0000_0100.
REQ-036 redirect_i and imem_rvalid_i in same cycle -> no load, next request addr = redirect target.
REQ-037 RESET_PC=32'hFFFF_FFFC -> second request addr 32'h0000_0000, if_pc_plus4_o=0 for first instruction.
REQ-038 With IF_PERF_COUNT_EN: 10 fetches, 2 redirects -> fetch_count_o=10, flush_count_o=2; async reset mid-stream -> both 0.

Source files
------------

// File: rtl/if_stage_if.sv
// -----------------------------------------------------------------------------
// if_stage_if -- instruction-memory read bus between the fetch stage and the
// instruction memory.
//
// Signals (named from the fetch stage's point of view):
//   imem_req_o     1  read request, one-cycle pulse per fetch
//   imem_addr_o   32  word-aligned fetch address, valid while imem_req_o=1
//   imem_rvalid_i  1  read data valid (any cycle after the request)
//   imem_rdata_i  32  instruction word
//
// Modports:
//   master -- the fetch stage (drives request/address)
//   slave  -- the instruction memory (drives rvalid/rdata)
// -----------------------------------------------------------------------------
interface if_stage_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_rvalid_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_rvalid_i,
    output imem_rdata_i
  );
endinterface

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- instruction fetch stage with IF/ID pipeline register.
//
// Issues at most one instruction-memory read at a time, captures the returned
// word into the IF/ID register, and handles decode back-pressure (stall) and
// control-flow redirects (taken branch/jump flush and refetch).
//
// Parameters:
//   RESET_PC        first fetch address after reset (bits [1:0] forced to 00)
//
// Ports:
//   clk_i           clock, all state changes on the rising edge
//   rst_n_i         asynchronous active-low reset
//   stall_i         decode not accepting; IF/ID contents are held
//   redirect_i      taken branch/jump: flush IF/ID and refetch
//   redirect_pc_i   redirect target (bits [1:0] ignored)
//   imem            instruction-memory bus (if_stage_if.master)
//   if_valid_o      IF/ID holds a live instruction
//   if_pc_o         PC of the held instruction
//   if_pc_plus4_o   if_pc_o + 4 (modulo 2^32)
//   if_instr_o      held instruction (NOP after reset/flush)
//   if_opcode_o     if_instr_o[6:0]
//   if_funct3_o     if_instr_o[14:12]
//   if_funct7_o     if_instr_o[31:25]
//
// Optional build macro IF_PERF_COUNT_EN adds:
//   fetch_count_o   number of instructions loaded into IF/ID (saturating)
//   flush_count_o   number of redirect cycles (saturating)
// -----------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  if_stage_if.master  imem,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_pc_plus4_o,
  output logic [31:0] if_instr_o,
  output logic [6:0]  if_opcode_o,
  output logic [2:0]  if_funct3_o,
  output logic [6:0]  if_funct7_o
`ifdef IF_PERF_COUNT_EN
  ,
  output logic [31:0] fetch_count_o,
  output logic [31:0] flush_count_o
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [1:0] {
    IDLE,   // one cycle after reset, no request
    FETCH,  // issue a request when IF/ID can take the result
    WAIT,   // live request outstanding
    DRAIN   // flushed request outstanding; its data will be dropped
  } state_t;

  state_t      state_q;
  state_t      state_d;

  // The fetch PC is kept as a word address so bits [1:0] are zero by
  // construction and +1 wraps exactly like a byte PC modulo 2^32.
  logic [31:2] pc_q;
  logic [31:2] pc_d;

  logic        req;
  logic        load;

  // A response is only accepted in WAIT and only if no redirect coincides.
  assign load = (state_q == WAIT) && imem.imem_rvalid_i && !redirect_i;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave it unassigned and infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    req     = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end

      FETCH: begin
        // Only request when the result has somewhere to go: IF/ID is empty,
        // or its current occupant leaves at this edge.
        if (!redirect_i && (!if_valid_o || !stall_i)) begin
          req     = 1'b1;
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (imem.imem_rvalid_i) begin
          state_d = FETCH;
          if (!redirect_i) begin
            pc_d = pc_q + 30'd1;
          end
        end else if (redirect_i) begin
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        // The dropped response frees the bus; a redirect in the same cycle
        // still only retargets the PC, it cannot keep us waiting for a
        // response that will never come.
        if (imem.imem_rvalid_i) begin
          state_d = FETCH;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A redirect retargets the fetch PC from any state.
    if (redirect_i) begin
      pc_d = redirect_pc_i[31:2];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC[31:2];
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // IF/ID register. Priority: flush, then load, then consumption.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      if_valid_o <= 1'b0;
      if_pc_o    <= 32'h0000_0000;
      if_instr_o <= NOP;
    end else if (redirect_i) begin
      if_valid_o <= 1'b0;
      if_instr_o <= NOP;
    end else if (load) begin
      if_valid_o <= 1'b1;
      if_pc_o    <= {pc_q, 2'b00};
      if_instr_o <= imem.imem_rdata_i;
    end else if (!stall_i) begin
      if_valid_o <= 1'b0;
    end
  end

  assign imem.imem_req_o  = req;
  assign imem.imem_addr_o = {pc_q, 2'b00};

  assign if_pc_plus4_o = if_pc_o + 32'd4;
  assign if_opcode_o   = if_instr_o[6:0];
  assign if_funct3_o   = if_instr_o[14:12];
  assign if_funct7_o   = if_instr_o[31:25];

`ifdef IF_PERF_COUNT_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fetch_count_o <= 32'h0000_0000;
      flush_count_o <= 32'h0000_0000;
    end else begin
      if (load && (fetch_count_o != 32'hFFFF_FFFF)) begin
        fetch_count_o <= fetch_count_o + 32'd1;
      end
      if (redirect_i && (flush_count_o != 32'hFFFF_FFFF)) begin
        flush_count_o <= flush_count_o + 32'd1;
      end
    end
  end
`endif

endmodule
